// File: rtl/fp_addmul_sched_if.sv
// Shared types and the bundled request/datapath/response bus of fp_addmul_sched.
package fp_addmul_sched_pkg;
    typedef enum logic [0:0] { OP_ADD = 1'b0, OP_MUL = 1'b1 } fp_op_e;
    typedef enum logic [0:0] { FP32 = 1'b0, FP16 = 1'b1 } fp_fmt_e;
endpackage

interface fp_addmul_sched_if;
    import fp_addmul_sched_pkg::*;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    fp_op_e  [1:0]    req_op;
    fp_fmt_e [1:0]    req_fmt;
    logic [1:0][31:0] req_x;
    logic [1:0][31:0] req_y;

    fp_op_e           dp_opcode;
    fp_fmt_e          dp_fmt;
    logic [31:0]      dp_x;
    logic [31:0]      dp_y;
    logic [31:0]      dp_r;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_src;
    logic [31:0]      rsp_r;

    modport slave (
        input  req_valid, req_op, req_fmt, req_x, req_y, dp_r, rsp_ready,
        output req_ready, dp_opcode, dp_fmt, dp_x, dp_y, rsp_valid, rsp_src, rsp_r
    );

    modport master (
        output req_valid, req_op, req_fmt, req_x, req_y, dp_r, rsp_ready,
        input  req_ready, dp_opcode, dp_fmt, dp_x, dp_y, rsp_valid, rsp_src, rsp_r
    );
endinterface

// File: rtl/fp_addmul_sched.sv
// Two-port round-robin scheduler in front of a shared FP add/mul datapath with a credited response FIFO.
// Optional performance counters are enabled with the FP_SCHED_PERF_EN macro.
module fp_addmul_sched
    import fp_addmul_sched_pkg::*;
#(
    parameter int DP_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_addmul_sched_if.slave bus
`ifdef FP_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_issue0,
    output logic [31:0]      perf_issue1,
    output logic [31:0]      perf_stall
`endif
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(DP_LAT + 1);
    localparam int SW = CW + IW + 1;

    logic [1:0]        grant_s;
    logic              credit_ok_s;
    logic              issue_s;
    logic              issue_src_s;
    logic              rr_last_r;

    logic [DP_LAT-1:0] tok_v_r;
    logic [DP_LAT-1:0] tok_src_r;
    logic [IW-1:0]     inflight_s;
    logic              exit_s;
    logic              exit_src_s;

    logic [32:0]       mem_r [RSP_DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     rd_ptr_nx_s;
    logic [CW-1:0]     fifo_count_r;
    logic [CW-1:0]     count_nx_s;
    logic [32:0]       head_nx_s;
    logic              push_s;
    logic              pop_s;

    fp_op_e            dp_opcode_r;
    fp_fmt_e           dp_fmt_r;
    logic [31:0]       dp_x_r;
    logic [31:0]       dp_y_r;
    logic              rsp_valid_r;
    logic              rsp_src_r;
    logic [31:0]       rsp_r_r;

    // Count tokens currently travelling through the latency pipe.
    always_comb begin
        inflight_s = {IW{1'b0}};
        for (int i = 0; i < DP_LAT; i++) begin
            inflight_s = inflight_s + IW'(tok_v_r[i]);
        end
    end

    // Every accepted, not yet popped operation holds one FIFO slot in reserve.
    assign credit_ok_s = (SW'(fifo_count_r) + SW'(inflight_s)) < SW'(RSP_DEPTH);

    // Round-robin grant; gated off during reset and when out of credit.
    always_comb begin
        grant_s = 2'b00;
        if (rst_n && credit_ok_s) begin
            case (bus.req_valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = rr_last_r ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    assign bus.req_ready = grant_s;
    assign issue_s       = grant_s[0] | grant_s[1];
    assign issue_src_s   = grant_s[1];

    // Round-robin pointer remembers the last port that was granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last_r <= 1'b1;
        end else if (issue_s) begin
            rr_last_r <= issue_src_s;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

    // Operand registers feeding the datapath; they hold while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dp_opcode_r <= OP_ADD;
            dp_fmt_r    <= FP32;
            dp_x_r      <= 32'h0000_0000;
            dp_y_r      <= 32'h0000_0000;
        end else if (issue_s) begin
            dp_opcode_r <= bus.req_op[issue_src_s];
            dp_fmt_r    <= bus.req_fmt[issue_src_s];
            dp_x_r      <= bus.req_x[issue_src_s];
            dp_y_r      <= bus.req_y[issue_src_s];
        end else begin
            dp_opcode_r <= dp_opcode_r;
            dp_fmt_r    <= dp_fmt_r;
            dp_x_r      <= dp_x_r;
            dp_y_r      <= dp_y_r;
        end
    end

    assign bus.dp_opcode = dp_opcode_r;
    assign bus.dp_fmt    = dp_fmt_r;
    assign bus.dp_x      = dp_x_r;
    assign bus.dp_y      = dp_y_r;

    // Token pipe mirroring the datapath latency; the last stage marks dp_r as valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tok_v_r   <= {DP_LAT{1'b0}};
            tok_src_r <= {DP_LAT{1'b0}};
        end else begin
            for (int i = DP_LAT - 1; i >= 1; i--) begin
                tok_v_r[i]   <= tok_v_r[i-1];
                tok_src_r[i] <= tok_src_r[i-1];
            end
            tok_v_r[0]   <= issue_s;
            tok_src_r[0] <= issue_src_s;
        end
    end

    assign exit_s     = tok_v_r[DP_LAT-1];
    assign exit_src_s = tok_src_r[DP_LAT-1];
    assign push_s     = exit_s;
    assign pop_s      = rsp_valid_r & bus.rsp_ready;

    // Next FIFO occupancy, read pointer and head entry.
    always_comb begin
        rd_ptr_nx_s = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_nx_s = fifo_count_r + CW'(1);
            2'b01:   count_nx_s = fifo_count_r - CW'(1);
            default: count_nx_s = fifo_count_r;
        endcase
        // The pushed entry becomes the head only when the FIFO is otherwise empty.
        if (push_s && (wr_ptr_r == rd_ptr_nx_s)) begin
            head_nx_s = {exit_src_s, bus.dp_r};
        end else begin
            head_nx_s = mem_r[rd_ptr_nx_s];
        end
    end

    // FIFO storage; contents are qualified by the pointers so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {exit_src_s, bus.dp_r};
        end
    end

    // FIFO pointers, occupancy and the registered response head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            fifo_count_r <= {CW{1'b0}};
            rsp_valid_r  <= 1'b0;
            rsp_src_r    <= 1'b0;
            rsp_r_r      <= 32'h0000_0000;
        end else begin
            wr_ptr_r     <= push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
            rd_ptr_r     <= rd_ptr_nx_s;
            fifo_count_r <= count_nx_s;
            rsp_valid_r  <= (count_nx_s != {CW{1'b0}});
            if (count_nx_s != {CW{1'b0}}) begin
                rsp_src_r <= head_nx_s[32];
                rsp_r_r   <= head_nx_s[31:0];
            end else begin
                rsp_src_r <= rsp_src_r;
                rsp_r_r   <= rsp_r_r;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_src   = rsp_src_r;
    assign bus.rsp_r     = rsp_r_r;

`ifdef FP_SCHED_PERF_EN
    logic [31:0] perf_issue0_r;
    logic [31:0] perf_issue1_r;
    logic [31:0] perf_stall_r;
    logic        stall_s;

    assign stall_s = (bus.req_valid != 2'b00) && (grant_s == 2'b00);

    // Saturating issue and stall counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issue0_r <= 32'h0000_0000;
            perf_issue1_r <= 32'h0000_0000;
            perf_stall_r  <= 32'h0000_0000;
        end else begin
            if (grant_s[0] && (perf_issue0_r != 32'hFFFF_FFFF)) begin
                perf_issue0_r <= perf_issue0_r + 32'd1;
            end else begin
                perf_issue0_r <= perf_issue0_r;
            end
            if (grant_s[1] && (perf_issue1_r != 32'hFFFF_FFFF)) begin
                perf_issue1_r <= perf_issue1_r + 32'd1;
            end else begin
                perf_issue1_r <= perf_issue1_r;
            end
            if (stall_s && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
        end
    end

    assign perf_issue0 = perf_issue0_r;
    assign perf_issue1 = perf_issue1_r;
    assign perf_stall  = perf_stall_r;
`endif

endmodule
